avalon_spi_fifo_ctrl: RTL and testbench

AVALON_SPI_FIFO_CTRL -- requirements
Module: avalon_spi_fifo_ctrl

---
 rtl/avalon_spi_fifo_ctrl.sv | 169 ++++++++++++++++
 tb/tb_avalon_spi_fifo_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/avalon_spi_fifo_ctrl.sv
// avalon_spi_fifo_ctrl: Avalon-MM slave with TX/RX FIFOs feeding a one-word-at-a-time SPI engine.
// Host reads take one wait cycle; read_data is captured at the end of that wait cycle.
module avalon_spi_fifo_ctrl #(
    parameter int DATA_W   = 32,
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8,
    parameter int NUM_CS   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chip_select,
    input  logic [7:0]        address,
    input  logic              write,
    input  logic [31:0]       write_data,
    input  logic              read,
    output logic [31:0]       read_data,
    output logic              wait_request,
    output logic              irq,
    output logic              go_transfer,
    output logic [DATA_W-1:0] data_write_to_spi,
    output logic [NUM_CS-1:0] cs_sel,
    input  logic              data_pack_ready,
    input  logic [DATA_W-1:0] data_read_from_spi
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [TAW:0] TX_FULL = (TAW+1)'(TX_DEPTH);
    localparam logic [RAW:0] RX_FULL = (RAW+1)'(RX_DEPTH);

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, CAPTURE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];
    logic [DATA_W-1:0] tx_mem_d [TX_DEPTH];
    logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];
    logic [DATA_W-1:0] rx_mem_d [RX_DEPTH];
    logic [TAW-1:0]    tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [RAW-1:0]    rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [TAW:0]      tx_cnt_q, tx_cnt_d;
    logic [RAW:0]      rx_cnt_q, rx_cnt_d;
    logic [10:0]       ctrl_q, ctrl_d;
    logic [3:0]        flags_q, flags_d;
    logic [31:0]       read_data_q, read_data_d;
    logic              acc_q, acc_d, rd_ok_q, rd_ok_d, irq_q, irq_d, go_q, go_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [NUM_CS-1:0] cs_q, cs_d, cs_dec;
    logic [2:0]        sync_q, sync_d;

    logic        access, rd_load, wr_acc, rd_acc;
    logic        tx_full, tx_empty, rx_full, rx_empty, busy, done, cap;
    logic        tx_push, tx_pop, rx_push, rx_pop;
    logic [3:0]  flag_set, flag_clr;
    logic [31:0] rd_mux;

    always_comb begin
        access   = chip_select & (read | write);
        rd_load  = access & ~acc_q & read;
        wr_acc   = access & acc_q & write;
        rd_acc   = access & acc_q & read;
        tx_full  = tx_cnt_q == TX_FULL;
        tx_empty = tx_cnt_q == '0;
        rx_full  = rx_cnt_q == RX_FULL;
        rx_empty = rx_cnt_q == '0;
        busy     = state_q != IDLE;
        done     = sync_q[2] & ~sync_q[1];
        cap      = state_q == CAPTURE;
        tx_push  = wr_acc & (address == 8'h00) & ~tx_full;
        tx_pop   = state_q == LAUNCH;
        rx_push  = cap & ctrl_q[3] & ~rx_full;
        // The empty/non-empty decision is taken when read_data is captured, so pop and data agree
        rx_pop   = rd_acc & (address == 8'h01) & rd_ok_q;
        flag_set = {cap & tx_empty,
                    rd_acc & (address == 8'h01) & ~rd_ok_q,
                    cap & ctrl_q[3] & rx_full,
                    wr_acc & (address == 8'h00) & tx_full};
        flag_clr = (wr_acc && address == 8'h04) ? write_data[3:0] : 4'h0;
        cs_dec   = '0;
        for (int i = 0; i < NUM_CS; i++)
            cs_dec[i] = 32'(ctrl_q[10:8]) == i;
        case (address)
            8'h01:   rd_mux = rx_empty ? 32'h0 : 32'(rx_mem_q[rx_rp_q]);
            8'h02:   rd_mux = {8'h0, 8'(rx_cnt_q), 8'(tx_cnt_q), 3'b0,
                               rx_empty, rx_full, tx_empty, tx_full, busy};
            8'h03:   rd_mux = 32'(ctrl_q);
            8'h04:   rd_mux = 32'(flags_q);
            default: rd_mux = 32'h0;
        endcase
    end

    always_comb begin
        acc_d       = access & ~acc_q;
        rd_ok_d     = rd_load ? ~rx_empty : rd_ok_q;
        read_data_d = rd_load ? rd_mux : read_data_q;
        ctrl_d      = (wr_acc && address == 8'h03) ? (write_data[10:0] & 11'h70F) : ctrl_q;
        flags_d     = (flags_q & ~flag_clr) | flag_set;
        irq_d       = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & flags_q[3]) |
                      (ctrl_q[2] & (|flags_q[2:0]));
        sync_d      = {sync_q[1:0], data_pack_ready};
        state_d     = (state_q == IDLE)   ? (tx_empty ? IDLE : LAUNCH) :
                      (state_q == LAUNCH) ? BUSY :
                      (state_q == BUSY)   ? (done ? CAPTURE : BUSY) : IDLE;
        go_d        = (state_q == IDLE) & ~tx_empty;
        dout_d      = go_d ? tx_mem_q[tx_rp_q] : dout_q;
        cs_d        = go_d ? cs_dec : cs_q;
        tx_mem_d    = tx_mem_q;
        if (tx_push)
            tx_mem_d[tx_wp_q] = write_data[DATA_W-1:0];
        rx_mem_d    = rx_mem_q;
        if (rx_push)
            rx_mem_d[rx_wp_q] = data_read_from_spi;
        tx_wp_d     = tx_wp_q + TAW'(tx_push);
        tx_rp_d     = tx_rp_q + TAW'(tx_pop);
        tx_cnt_d    = tx_cnt_q + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
        rx_wp_d     = rx_wp_q + RAW'(rx_push);
        rx_rp_d     = rx_rp_q + RAW'(rx_pop);
        rx_cnt_d    = rx_cnt_q + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            tx_mem_q    <= '{default: '0};
            rx_mem_q    <= '{default: '0};
            tx_wp_q     <= '0;
            tx_rp_q     <= '0;
            tx_cnt_q    <= '0;
            rx_wp_q     <= '0;
            rx_rp_q     <= '0;
            rx_cnt_q    <= '0;
            ctrl_q      <= '0;
            flags_q     <= '0;
            read_data_q <= '0;
            acc_q       <= 1'b0;
            rd_ok_q     <= 1'b0;
            irq_q       <= 1'b0;
            go_q        <= 1'b0;
            dout_q      <= '0;
            cs_q        <= '0;
            sync_q      <= '0;
        end else begin
            state_q     <= state_d;
            tx_mem_q    <= tx_mem_d;
            rx_mem_q    <= rx_mem_d;
            tx_wp_q     <= tx_wp_d;
            tx_rp_q     <= tx_rp_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_wp_q     <= rx_wp_d;
            rx_rp_q     <= rx_rp_d;
            rx_cnt_q    <= rx_cnt_d;
            ctrl_q      <= ctrl_d;
            flags_q     <= flags_d;
            read_data_q <= read_data_d;
            acc_q       <= acc_d;
            rd_ok_q     <= rd_ok_d;
            irq_q       <= irq_d;
            go_q        <= go_d;
            dout_q      <= dout_d;
            cs_q        <= cs_d;
            sync_q      <= sync_d;
        end
    end

    assign read_data         = read_data_q;
    assign wait_request      = access & ~acc_q;
    assign irq               = irq_q;
    assign go_transfer       = go_q;
    assign data_write_to_spi = dout_q;
    assign cs_sel            = cs_q;
endmodule

// File: tb/tb_avalon_spi_fifo_ctrl.sv
// tb_avalon_spi_fifo_ctrl: directed stimulus; expected reads and SPI launches are queued
// and a negedge monitor pops them whenever the DUT presents a read result or go_transfer.
module tb_avalon_spi_fifo_ctrl;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        chip_select = 1'b0, write = 1'b0, read = 1'b0, data_pack_ready = 1'b1;
    logic [7:0]  address = '0;
    logic [31:0] write_data = '0, data_read_from_spi = '0;
    logic [31:0] read_data, data_write_to_spi;
    logic        wait_request, irq, go_transfer;
    logic [3:0]  cs_sel;

    int checks = 0, failures = 0;
    logic [31:0] exp_rd[$];
    logic [35:0] exp_go[$];

    always #5 clk = ~clk;

    avalon_spi_fifo_ctrl dut (
        .clk(clk), .reset_n(reset_n), .chip_select(chip_select), .address(address),
        .write(write), .write_data(write_data), .read(read), .read_data(read_data),
        .wait_request(wait_request), .irq(irq), .go_transfer(go_transfer),
        .data_write_to_spi(data_write_to_spi), .cs_sel(cs_sel),
        .data_pack_ready(data_pack_ready), .data_read_from_spi(data_read_from_spi)
    );

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chip_select && read && !wait_request) begin
            if (exp_rd.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected got=%h expected=none", read_data);
            end else
                chk("rd_data", 36'(read_data), 36'(exp_rd.pop_front()));
        end
        if (go_transfer) begin
            if (exp_go.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL go_unexpected got=%h expected=none", data_write_to_spi);
            end else
                chk("go_transfer", {cs_sel, data_write_to_spi}, exp_go.pop_front());
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bus(input logic rd, input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        chip_select = 1'b1; read = rd; write = !rd; address = a; write_data = d;
        @(negedge clk); chk("wait_hi", 36'(wait_request), 36'd1);
        @(negedge clk); chk("wait_lo", 36'(wait_request), 36'd0);
        @(posedge clk); #1;
        chip_select = 1'b0; read = 1'b0; write = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus(1'b0, a, d);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e);
        exp_rd.push_back(e);
        bus(1'b1, a, 32'h0);
    endtask

    task automatic complete(input logic [31:0] w);
        data_read_from_spi = w;
        data_pack_ready = 1'b0;
        cyc(6);
        data_pack_ready = 1'b1;
        cyc(6);
    endtask

    task automatic chk_irq(input logic e);
        cyc(3);
        @(negedge clk);
        chk("irq", 36'(irq), 36'(e));
    endtask

    initial begin
        cyc(3);
        @(negedge clk);
        chk("rst_read_data", 36'(read_data), 36'd0);
        chk("rst_outputs", {irq, go_transfer, wait_request, cs_sel}, 36'd0);
        chk("rst_dout", 36'(data_write_to_spi), 36'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        cyc(5);

        // Basic transfer on slave 1 with capture enabled
        wr(8'h03, 32'h0000_0108);
        rd(8'h03, 32'h0000_0108);
        exp_go.push_back({4'b0010, 32'hA5A5_1234});
        wr(8'h00, 32'hA5A5_1234);
        cyc(4);
        rd(8'h02, 32'h0000_0015);
        complete(32'hDEAD_BEEF);
        rd(8'h02, 32'h0001_0004);
        rd(8'h04, 32'h0000_0008);
        rd(8'h01, 32'hDEAD_BEEF);
        rd(8'h02, 32'h0000_0014);

        // Underflow, with error interrupt first disabled then enabled
        rd(8'h01, 32'h0);
        rd(8'h04, 32'h0000_000C);
        chk_irq(1'b0);
        wr(8'h03, 32'h0000_010C);
        chk_irq(1'b1);
        wr(8'h04, 32'h0000_000F);
        chk_irq(1'b0);
        rd(8'h04, 32'h0);

        // Overfill TX while the engine sits in BUSY
        exp_go.push_back({4'b0010, 32'h1000_0000});
        wr(8'h00, 32'h1000_0000);
        cyc(4);
        for (int k = 1; k <= 9; k++) begin
            if (k <= 8) exp_go.push_back({4'b0010, 32'h10 + 32'(k)});
            wr(8'h00, 32'h10 + 32'(k));
        end
        rd(8'h02, 32'h0000_0813);
        rd(8'h04, 32'h0000_0001);
        wr(8'h04, 32'h0000_0001);
        rd(8'h04, 32'h0);

        // Drain: nine completions into an eight-deep RX FIFO
        for (int k = 0; k < 9; k++) complete(32'hC000_0000 + 32'(k));
        rd(8'h02, 32'h0008_000C);
        rd(8'h04, 32'h0000_000A);
        for (int k = 0; k < 8; k++) rd(8'h01, 32'hC000_0000 + 32'(k));
        rd(8'h01, 32'h0);
        rd(8'h04, 32'h0000_000E);

        // Out-of-range slave index, then reset in the middle of a transfer
        wr(8'h03, 32'h0000_050C);
        chk_irq(1'b1);
        exp_go.push_back({4'b0000, 32'h5555_AAAA});
        wr(8'h00, 32'h5555_AAAA);
        cyc(4);
        rd(8'h03, 32'h0000_050C);
        @(posedge clk); #1 reset_n = 1'b0;
        #1;
        chk("midrst_dout", 36'(data_write_to_spi), 36'd0);
        chk("midrst_read_data", 36'(read_data), 36'd0);
        chk("midrst_outputs", {irq, go_transfer, cs_sel}, 36'd0);
        cyc(3);
        @(posedge clk); #1 reset_n = 1'b1;
        cyc(20);
        rd(8'h02, 32'h0000_0014);
        rd(8'h03, 32'h0);
        rd(8'h04, 32'h0);
        exp_go.push_back({4'b0001, 32'h0000_0077});
        wr(8'h00, 32'h0000_0077);
        cyc(10);

        chk("rd_queue_drained", 36'(exp_rd.size()), 36'd0);
        chk("go_queue_drained", 36'(exp_go.size()), 36'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
